bin2ascii_display: RTL and testbench

- Sequential binary-to-ASCII formatter for the four-digit seven-segment driver.
- Accepts an unsigned binary value over a valid/ready handshake.
- Converts the value to four decimal digits with a shift-add-3 (double-dabble) engine.
- Drives registered ASCII bytes on display_0..display_3, plus a decimal-place code, straight into the display driver's inputs.

---
 rtl/bin2ascii_display.sv | 89 ++++++++
 tb/tb_bin2ascii_display.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bin2ascii_display.sv
// bin2ascii_display: serial double-dabble binary to four-digit ASCII formatter for the seven-segment driver
//   clk, rst         : clock, asynchronous active-high reset
//   in_valid/ready   : handshake for in_value (WIDTH bits) and in_dp (2 bits)
//   display_0..3     : registered ASCII digits, display_0 = thousands, display_3 = units
//   decplace         : in_dp captured with the value, updated with the digits
//   overflow         : last accepted value exceeded 9999 (digits shown as '-')
//   busy             : conversion in progress
module bin2ascii_display #(
  parameter int WIDTH    = 14,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  input  logic [1:0]       in_dp,
  output logic [7:0]       display_0,
  output logic [7:0]       display_1,
  output logic [7:0]       display_2,
  output logic [7:0]       display_3,
  output logic [1:0]       decplace,
  output logic             overflow,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;
  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [15:0]      bcd, bcd_adj;
  logic [CW-1:0]    cnt;
  logic [1:0]       dp_hold;
  logic             ovf_pend;
  logic             blank_0, blank_1, blank_2;
  assign in_ready = state == IDLE;
  assign busy     = state != IDLE;
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++)
      bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  // blanking chains from the left so an inner zero (e.g. 1 0 5) is kept
  assign blank_0 = BLANK_LZ && bcd[15:12] == 4'd0;
  assign blank_1 = blank_0 && bcd[11:8] == 4'd0;
  assign blank_2 = blank_1 && bcd[7:4] == 4'd0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bcd       <= '0;
      cnt       <= '0;
      dp_hold   <= '0;
      ovf_pend  <= 1'b0;
      display_0 <= 8'h20;
      display_1 <= 8'h20;
      display_2 <= 8'h20;
      display_3 <= 8'h20;
      decplace  <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          shreg    <= in_value;
          dp_hold  <= in_dp;
          ovf_pend <= 32'(in_value) > 32'd9999;
          bcd      <= '0;
          cnt      <= CW'(WIDTH);
          state    <= SHIFT;
        end
        SHIFT: begin
          // carries out of bcd[15] are dropped; such values are already flagged as overflow
          bcd   <= {bcd_adj[14:0], shreg[WIDTH-1]};
          shreg <= shreg << 1;
          cnt   <= cnt - 1'b1;
          state <= cnt == CW'(1) ? FORMAT : SHIFT;
        end
        default: begin
          display_0 <= ovf_pend ? 8'h2D : blank_0 ? 8'h20 : {4'h3, bcd[15:12]};
          display_1 <= ovf_pend ? 8'h2D : blank_1 ? 8'h20 : {4'h3, bcd[11:8]};
          display_2 <= ovf_pend ? 8'h2D : blank_2 ? 8'h20 : {4'h3, bcd[7:4]};
          display_3 <= ovf_pend ? 8'h2D : {4'h3, bcd[3:0]};
          overflow  <= ovf_pend;
          decplace  <= dp_hold;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bin2ascii_display.sv
// tb_bin2ascii_display: directed self-checking bench for bin2ascii_display (blanking and zero-fill builds)
module tb_bin2ascii_display;
  localparam int W = 14;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_value = '0;
  logic [1:0]   in_dp = '0;
  logic         in_ready, overflow, busy;
  logic [7:0]   display_0, display_1, display_2, display_3;
  logic [1:0]   decplace;
  logic         z_ready, z_overflow, z_busy;
  logic [7:0]   z_0, z_1, z_2, z_3;
  logic [1:0]   z_decplace;
  logic [31:0]  disp, zdisp;
  int           errors = 0;
  int           checks = 0;
  assign disp  = {display_0, display_1, display_2, display_3};
  assign zdisp = {z_0, z_1, z_2, z_3};
  always #5 clk = ~clk;
  bin2ascii_display #(.WIDTH(W), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value), .in_dp(in_dp),
    .display_0(display_0), .display_1(display_1), .display_2(display_2), .display_3(display_3),
    .decplace(decplace), .overflow(overflow), .busy(busy));
  bin2ascii_display #(.WIDTH(W), .BLANK_LZ(1'b0)) dut_z (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(z_ready), .in_value(in_value), .in_dp(in_dp),
    .display_0(z_0), .display_1(z_1), .display_2(z_2), .display_3(z_3),
    .decplace(z_decplace), .overflow(z_overflow), .busy(z_busy));

  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1; k++;
    end
    checks++;
    if (!in_ready) begin errors++; $display("FAIL ready_timeout: in_ready got %b want 1", in_ready); end
  endtask

  // handshake one value, then count edges until in_ready returns; quiet = outputs held and busy set meanwhile
  task automatic send(input logic [W-1:0] v, input logic [1:0] dp, output int lat, output bit quiet);
    logic [31:0] pre;
    wait_ready();
    pre = disp;
    in_valid = 1'b1; in_value = v; in_dp = dp;
    @(posedge clk); #1;
    in_valid = 1'b0; in_value = ~v; in_dp = ~dp;
    lat = 0; quiet = 1'b1;
    while (lat < 100) begin
      @(posedge clk); #1; lat++;
      if (in_ready) break;
      if (disp !== pre || busy !== 1'b1) quiet = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (disp !== 32'h20202020) begin errors++; $display("FAIL rst_disp: got %h want %h", disp, 32'h20202020); end
    checks++; if ({decplace, overflow} !== 3'b000) begin errors++; $display("FAIL rst_dp_ovf: got %b want 000", {decplace, overflow}); end
    checks++; if ({in_ready, busy} !== 2'b10) begin errors++; $display("FAIL rst_ready_busy: got %b want 10", {in_ready, busy}); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat; bit quiet;
    send(14'd1234, 2'd2, lat, quiet);
    checks++; if (lat !== W + 1) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, W + 1); end
    checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL basic_quiet: got %b want 1", quiet); end
    checks++; if (disp !== 32'h31323334) begin errors++; $display("FAIL basic_disp: got %h want %h", disp, 32'h31323334); end
    checks++; if ({decplace, overflow} !== 3'b100) begin errors++; $display("FAIL basic_dp_ovf: got %b want 100", {decplace, overflow}); end
    checks++; if (zdisp !== 32'h31323334) begin errors++; $display("FAIL basic_zdisp: got %h want %h", zdisp, 32'h31323334); end
  endtask

  task automatic test_blanking();
    int lat; bit quiet;
    send(14'd7, 2'd1, lat, quiet);
    checks++; if (disp !== 32'h20202037) begin errors++; $display("FAIL blank7_disp: got %h want %h", disp, 32'h20202037); end
    checks++; if (zdisp !== 32'h30303037) begin errors++; $display("FAIL zero7_disp: got %h want %h", zdisp, 32'h30303037); end
    send(14'd0, 2'd0, lat, quiet);
    checks++; if (disp !== 32'h20202030) begin errors++; $display("FAIL blank0_disp: got %h want %h", disp, 32'h20202030); end
    checks++; if (zdisp !== 32'h30303030) begin errors++; $display("FAIL zero0_disp: got %h want %h", zdisp, 32'h30303030); end
    send(14'd1005, 2'd0, lat, quiet);
    checks++; if (disp !== 32'h31303035) begin errors++; $display("FAIL inner_zero_disp: got %h want %h", disp, 32'h31303035); end
    send(14'd9999, 2'd3, lat, quiet);
    checks++; if (disp !== 32'h39393939) begin errors++; $display("FAIL max_disp: got %h want %h", disp, 32'h39393939); end
    checks++; if ({decplace, overflow} !== 3'b110) begin errors++; $display("FAIL max_dp_ovf: got %b want 110", {decplace, overflow}); end
  endtask

  task automatic test_overflow();
    int lat; bit quiet;
    send(14'd10000, 2'd1, lat, quiet);
    checks++; if (lat !== W + 1) begin errors++; $display("FAIL ovf_latency: got %0d want %0d", lat, W + 1); end
    checks++; if (disp !== 32'h2D2D2D2D) begin errors++; $display("FAIL ovf10000_disp: got %h want %h", disp, 32'h2D2D2D2D); end
    checks++; if ({decplace, overflow} !== 3'b011) begin errors++; $display("FAIL ovf10000_dp_ovf: got %b want 011", {decplace, overflow}); end
    send(14'd16383, 2'd2, lat, quiet);
    checks++; if (lat !== W + 1) begin errors++; $display("FAIL ovfmax_latency: got %0d want %0d", lat, W + 1); end
    checks++; if ({disp, overflow} !== {32'h2D2D2D2D, 1'b1}) begin errors++; $display("FAIL ovfmax: got %h/%b want 2d2d2d2d/1", disp, overflow); end
    checks++; if ({zdisp, z_overflow} !== {32'h2D2D2D2D, 1'b1}) begin errors++; $display("FAIL ovfmax_z: got %h/%b want 2d2d2d2d/1", zdisp, z_overflow); end
    send(14'd42, 2'd0, lat, quiet);
    checks++; if ({disp, overflow} !== {32'h20203432, 1'b0}) begin errors++; $display("FAIL after_ovf42: got %h/%b want 20203432/0", disp, overflow); end
    checks++; if (zdisp !== 32'h30303432) begin errors++; $display("FAIL after_ovf42_z: got %h want %h", zdisp, 32'h30303432); end
  endtask

  task automatic test_back_to_back();
    int t = 0;
    int acc2 = -1;
    bit done = 1'b0;
    wait_ready();
    in_valid = 1'b1; in_value = 14'd1111; in_dp = 2'd1;
    @(posedge clk); #1;
    for (int k = 0; k < 60 && !done; k++) begin
      @(posedge clk); #1; t++;
      if (acc2 < 0 && in_ready) begin
        checks++; if (t !== W + 1 || disp !== 32'h31313131) begin errors++; $display("FAIL b2b_first: got t=%0d %h want t=%0d 31313131", t, disp, W + 1); end
        in_value = 14'd2222; in_dp = 2'd3; acc2 = t + 1;
      end else if (acc2 < 0) begin
        in_value = 14'(8000 + t); in_dp = 2'(t);
      end else if (t == acc2) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept: in_ready got %b want 0", in_ready); end
        in_valid = 1'b0; in_value = 14'd5;
      end else if (in_ready) begin
        done = 1'b1;
        checks++; if (acc2 !== W + 2) begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", acc2, W + 2); end
        checks++; if (t - acc2 !== W + 1) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", t - acc2, W + 1); end
        checks++; if ({disp, decplace} !== {32'h32323232, 2'd3}) begin errors++; $display("FAIL b2b_second: got %h/%0d want 32323232/3", disp, decplace); end
      end
    end
    in_valid = 1'b0;
    checks++; if (!done) begin errors++; $display("FAIL b2b_timeout: done got 0 want 1"); end
  endtask

  task automatic test_reset_mid_shift();
    int lat; bit quiet; bit clean = 1'b1;
    wait_ready();
    in_valid = 1'b1; in_value = 14'd5555; in_dp = 2'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (disp !== 32'h20202020) begin errors++; $display("FAIL midrst_disp: got %h want %h", disp, 32'h20202020); end
    checks++; if ({decplace, overflow, in_ready, busy} !== 5'b00010) begin errors++; $display("FAIL midrst_ctrl: got %b want 00010", {decplace, overflow, in_ready, busy}); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (W + 4) begin
      @(posedge clk); #1;
      if (disp !== 32'h20202020 || busy !== 1'b0) clean = 1'b0;
    end
    checks++; if (clean !== 1'b1) begin errors++; $display("FAIL midrst_stale: got %h want 20202020 and idle", disp); end
    send(14'd321, 2'd1, lat, quiet);
    checks++; if (lat !== W + 1) begin errors++; $display("FAIL postrst_latency: got %0d want %0d", lat, W + 1); end
    checks++; if ({disp, decplace} !== {32'h20333231, 2'd1}) begin errors++; $display("FAIL postrst_disp: got %h/%0d want 20333231/1", disp, decplace); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_blanking();
    test_overflow();
    test_back_to_back();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
